// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU fetch/sequencing path.
// FETCH_ALIGN_CHECK_EN adds the HALT state used by the misaligned-PC trap.
package cpu_pkg;

   `ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {
      FETCH,
      LATCH,
      EXEC,
      DMEM,
      DWAIT,
      HALT
   } fetch_state_t;
   `else
   typedef enum logic [2:0] {
      FETCH,
      LATCH,
      EXEC,
      DMEM,
      DWAIT
   } fetch_state_t;
   `endif

   // Decoder PCSrc encodings; 2'b11 is reserved and treated as sequential.
   localparam logic [1:0] PC_BR   = 2'b00;
   localparam logic [1:0] PC_RIND = 2'b01;
   localparam logic [1:0] PC_SEQ  = 2'b10;

   localparam int unsigned OPC_LSB   = 0;
   localparam int unsigned OPC_MSB   = 4;
   localparam int unsigned RX_LSB    = 5;
   localparam int unsigned RX_MSB    = 7;
   localparam int unsigned RY_LSB    = 8;
   localparam int unsigned RY_MSB    = 10;
   localparam int unsigned IMM8_LSB  = 8;
   localparam int unsigned IMM8_MSB  = 15;
   localparam int unsigned IMM11_LSB = 5;
   localparam int unsigned IMM11_MSB = 15;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch unit, including the optional alignment check
// enabled by FETCH_ALIGN_CHECK_EN.
module fetch_pc_sel
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = 16
) (
   input  logic [PC_W-1:0] pc,
   input  logic [1:0]      pc_src,
   input  logic            pc_enable,
   input  logic [PC_W-1:0] br_target,
   input  logic [PC_W-1:0] rind_target,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic            misaligned,
`endif
   output logic [PC_W-1:0] next_pc
);

   logic [PC_W-1:0] sel;

   always_comb begin
      sel = pc + PC_W'(2);
      if (!pc_enable) begin
         sel = pc;
      end else begin
         case (pc_src)
            PC_BR:   sel = br_target;
            PC_RIND: sel = rind_target;
            default: sel = pc + PC_W'(2);
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = sel[0];
   assign next_pc    = sel;
`else
   assign next_pc    = sel & ~PC_W'(1);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing: PC, IR, shared memory port arbitration.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned next-PC values into HALT.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned          PC_W     = 16,
   parameter int unsigned          INSTR_W  = 16,
   parameter logic [PC_W-1:0]      RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    o_mem_addr,
   output logic               o_mem_rd,
   output logic               o_mem_wr,
   output logic [INSTR_W-1:0] o_mem_wrdata,
   input  logic [INSTR_W-1:0] i_mem_rddata,
   output logic [INSTR_W-1:0] o_instr,
   output logic [4:0]         o_opcode,
   output logic [PC_W-1:0]    o_pc,
   output logic [PC_W-1:0]    o_pc_plus2,
   output logic               o_exec,
   output logic               o_ld_valid,
   input  logic [1:0]         i_pc_src,
   input  logic               i_pc_enable,
   input  logic               i_mem_sel,
   input  logic               i_mem_write,
   input  logic [PC_W-1:0]    i_br_target,
   input  logic [PC_W-1:0]    i_rind_target,
   input  logic [PC_W-1:0]    i_data_addr,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic               o_fault,
`endif
   input  logic [INSTR_W-1:0] i_data_wrdata
);

   fetch_state_t       state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    next_pc;
   logic               pc_commit;
   logic               trap;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;
   logic misaligned;

   assign trap    = misaligned;
   assign o_fault = fault_q;
`else
   assign trap    = 1'b0;
`endif

   fetch_pc_sel #(.PC_W(PC_W)) u_pc_sel (
      .pc          (pc),
      .pc_src      (i_pc_src),
      .pc_enable   (i_pc_enable),
      .br_target   (i_br_target),
      .rind_target (i_rind_target),
`ifdef FETCH_ALIGN_CHECK_EN
      .misaligned  (misaligned),
`endif
      .next_pc     (next_pc)
   );

   // The instruction retires (PC may move) at the last cycle of its sequence.
   always_comb begin
      pc_commit = 1'b0;
      case (state)
         EXEC:    pc_commit = !i_mem_sel;
         DMEM:    pc_commit = i_mem_write;
         DWAIT:   pc_commit = 1'b1;
         default: pc_commit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: state <= LATCH;
            LATCH: begin
               ir    <= i_mem_rddata;
               state <= EXEC;
            end
            EXEC, DMEM, DWAIT: begin
               if (pc_commit) begin
                  if (trap) begin
`ifdef FETCH_ALIGN_CHECK_EN
                     state   <= HALT;
                     fault_q <= 1'b1;
`endif
                  end else begin
                     pc    <= next_pc;
                     state <= FETCH;
                  end
               end else if (state == EXEC) begin
                  state <= DMEM;
               end else begin
                  state <= DWAIT;
               end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            HALT: state <= HALT;
`endif
            default: state <= FETCH;
         endcase
      end
   end

   // Strobes are gated by reset so an access in flight is dropped immediately.
   always_comb begin
      o_mem_addr = pc;
      o_mem_rd   = 1'b0;
      o_mem_wr   = 1'b0;
      o_exec     = 1'b0;
      o_ld_valid = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: o_mem_rd = 1'b1;
            EXEC:  o_exec   = 1'b1;
            DMEM: begin
               o_mem_addr = i_data_addr;
               o_mem_wr   = i_mem_write;
               o_mem_rd   = !i_mem_write;
            end
            DWAIT:   o_ld_valid = 1'b1;
            default: ;
         endcase
      end else if (state == DMEM) begin
         o_mem_addr = i_data_addr;
      end
   end

   assign o_mem_wrdata = i_data_wrdata;
   assign o_instr      = ir;
   assign o_opcode     = ir[OPC_MSB:OPC_LSB];
   assign o_pc         = pc;
   assign o_pc_plus2   = pc + PC_W'(2);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle-latency memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] o_mem_addr;
   logic        o_mem_rd;
   logic        o_mem_wr;
   logic [15:0] o_mem_wrdata;
   logic [15:0] mem_rddata = '0;
   logic [15:0] o_instr;
   logic [4:0]  o_opcode;
   logic [15:0] o_pc;
   logic [15:0] o_pc_plus2;
   logic        o_exec;
   logic        o_ld_valid;
   logic [1:0]  pc_src;
   logic        pc_en;
   logic        mem_sel;
   logic        mem_write;
   logic [15:0] br_target;
   logic [15:0] rind_target;
   logic [15:0] data_addr;
   logic [15:0] data_wrdata;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        o_fault;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int wr_count = 0;
   int overlap  = 0;
   int wc;

   logic [15:0] mem [0:65535];

   fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .o_mem_addr    (o_mem_addr),
      .o_mem_rd      (o_mem_rd),
      .o_mem_wr      (o_mem_wr),
      .o_mem_wrdata  (o_mem_wrdata),
      .i_mem_rddata  (mem_rddata),
      .o_instr       (o_instr),
      .o_opcode      (o_opcode),
      .o_pc          (o_pc),
      .o_pc_plus2    (o_pc_plus2),
      .o_exec        (o_exec),
      .o_ld_valid    (o_ld_valid),
      .i_pc_src      (pc_src),
      .i_pc_enable   (pc_en),
      .i_mem_sel     (mem_sel),
      .i_mem_write   (mem_write),
      .i_br_target   (br_target),
      .i_rind_target (rind_target),
      .i_data_addr   (data_addr),
`ifdef FETCH_ALIGN_CHECK_EN
      .o_fault       (o_fault),
`endif
      .i_data_wrdata (data_wrdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_mem_rd) mem_rddata <= mem[o_mem_addr];
      if (o_mem_wr) wr_count <= wr_count + 1;
      if (o_mem_rd && o_mem_wr) overlap <= overlap + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h0000] = 16'h0120;
      mem[16'h0002] = 16'h0021;
      mem[16'h0200] = 16'hBEEF;

      reset = 1'b1; pc_src = 2'b10; pc_en = 1'b1; mem_sel = 1'b0; mem_write = 1'b0;
      br_target = '0; rind_target = '0; data_addr = '0; data_wrdata = 16'h1234;
      step(); step(); step();
      chk("rst_rd", o_mem_rd, 0);
      chk("rst_exec", o_exec, 0);
      chk("rst_pc", o_pc, 0);
      chk("rst_ir", o_instr, 0);
      chk("rst_ldv", o_ld_valid, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("rst_fault", o_fault, 0);
`endif

      // sequential run: mv at 0, add at 2
      reset = 1'b0; #1;
      chk("f0_rd", o_mem_rd, 1);
      chk("f0_addr", o_mem_addr, 16'h0000);
      step();
      chk("l0_rd", o_mem_rd, 0);
      chk("l0_exec", o_exec, 0);
      step();
      chk("e0_exec", o_exec, 1);
      chk("e0_opc", o_opcode, 5'b00000);
      chk("e0_instr", o_instr, 16'h0120);
      chk("e0_pc2", o_pc_plus2, 16'h0002);
      step();
      chk("f1_addr", o_mem_addr, 16'h0002);
      chk("f1_exec", o_exec, 0);
      chk("f1_pc", o_pc, 16'h0002);
      step(); step();
      chk("e1_exec", o_exec, 1);
      chk("e1_opc", o_opcode, 5'b00001);

      // branch then register-indirect
      pc_src = 2'b00; br_target = 16'h0040;
      step();
      chk("br_addr", o_mem_addr, 16'h0040);
      pc_src = 2'b01; rind_target = 16'h0100;
      step(); step(); step();
      chk("rind_addr", o_mem_addr, 16'h0100);

      // load: 5 cycles
      pc_src = 2'b10; mem_sel = 1'b1; mem_write = 1'b0; data_addr = 16'h0200;
      step(); step();
      chk("ld_exec", o_exec, 1);
      step();
      chk("ld_dm_addr", o_mem_addr, 16'h0200);
      chk("ld_dm_rd", o_mem_rd, 1);
      chk("ld_dm_wr", o_mem_wr, 0);
      chk("ld_dm_ldv", o_ld_valid, 0);
      step();
      chk("ld_valid", o_ld_valid, 1);
      chk("ld_data", mem_rddata, 16'hBEEF);
      chk("ld_wr", o_mem_wr, 0);
      chk("ld_pc", o_pc, 16'h0100);
      step();
      chk("ld_next", o_mem_addr, 16'h0102);
      chk("ld_next_rd", o_mem_rd, 1);

      // store: 4 cycles, one write strobe
      mem_write = 1'b1; data_addr = 16'h0210; wc = wr_count;
      step(); step(); step();
      chk("st_wr", o_mem_wr, 1);
      chk("st_rd", o_mem_rd, 0);
      chk("st_addr", o_mem_addr, 16'h0210);
      chk("st_wdata", o_mem_wrdata, 16'h1234);
      step();
      chk("st_next", o_mem_addr, 16'h0104);
      chk("st_wr_off", o_mem_wr, 0);
      chk("st_wr_count", wr_count - wc, 1);

      // hold
      mem_sel = 1'b0; mem_write = 1'b0; pc_en = 1'b0;
      step(); step(); step();
      chk("hold_addr", o_mem_addr, 16'h0104);
      pc_en = 1'b1;

      // wrap, using the reserved sequential encoding
      pc_src = 2'b00; br_target = 16'hFFFE;
      step(); step(); step();
      chk("wrap_pre", o_mem_addr, 16'hFFFE);
      chk("wrap_pc2", o_pc_plus2, 16'h0000);
      pc_src = 2'b11;
      step(); step(); step();
      chk("wrap_addr", o_mem_addr, 16'h0000);
      pc_src = 2'b10;
      step(); step(); step();
      chk("seq_addr", o_mem_addr, 16'h0002);

      // reset in DMEM of a load
      mem_sel = 1'b1; data_addr = 16'h0200;
      step(); step(); step();
      chk("mid_dm_rd", o_mem_rd, 1);
      reset = 1'b1; #1;
      chk("mid_rst_rd", o_mem_rd, 0);
      step();
      chk("mid_ldv", o_ld_valid, 0);
      chk("mid_pc", o_pc, 16'h0000);
      reset = 1'b0; mem_sel = 1'b0; #1;
      chk("mid_f_addr", o_mem_addr, 16'h0000);
      chk("mid_f_rd", o_mem_rd, 1);
      chk("mid_f_ldv", o_ld_valid, 0);

      // misaligned branch target
      pc_src = 2'b00; br_target = 16'h0013;
      step(); step(); step();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("al_fault", o_fault, 1);
      chk("al_rd", o_mem_rd, 0);
      chk("al_wr", o_mem_wr, 0);
      chk("al_exec", o_exec, 0);
      step(); step(); step();
      chk("al_fault_hold", o_fault, 1);
      chk("al_rd_hold", o_mem_rd, 0);
      chk("al_pc_hold", o_pc, 16'h0000);
`else
      chk("al_addr", o_mem_addr, 16'h0012);
      chk("al_rd", o_mem_rd, 1);
`endif

      chk("no_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and sequencing stage of the multicycle CPU, directly upstream of `opcode_decoder`. It owns the PC and instruction register (IR), drives the single shared memory port, and presents `o_opcode` to the decoder. It sequences each instruction through fetch, execute and optional data-memory cycles, using the decoder's `PCSrc`, `pc_enable` and `mem_sel`. It also arbitrates the one memory port between instruction and data accesses.

## Interface
- `PC_W`, 16: PC and memory address width.
- `INSTR_W`, 16: instruction and data word width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `o_mem_addr` out PC_W: shared memory address.
- `o_mem_rd` out 1: memory read strobe.
- `o_mem_wr` out 1: memory write strobe.
- `o_mem_wrdata` out INSTR_W: store data, passed through from `i_data_wrdata`.
- `i_mem_rddata` in INSTR_W: read data, valid the cycle after `o_mem_rd`.
- `o_instr` out INSTR_W: IR contents.
- `o_opcode` out 5: `IR[4:0]`, feeds the decoder.
- `o_pc` out PC_W: PC of the current instruction.
- `o_pc_plus2` out PC_W: `o_pc + 2`, used for the `WBSrc` and `call` link value.
- `o_exec` out 1: decoder outputs are valid and the datapath may commit `RegWrite`/`NZ`.
- `o_ld_valid` out 1: `i_mem_rddata` holds load data for writeback.
- `i_pc_src` in 2: decoder `PCSrc`. 00 = branch target, 01 = register-indirect, 10 = pc+2, 11 = pc+2 (reserved).
- `i_pc_enable` in 1: decoder `pc_enable`. 0 holds the PC, which re-executes the same instruction.
- `i_mem_sel` in 1: decoder `mem_sel`. 1 means the instruction needs a data access.
- `i_mem_write` in 1: decoder `MemWrite`.
- `i_br_target` in PC_W: `pc+2+2*imm` from the datapath.
- `i_rind_target` in PC_W: register value for `jr`, `jzr`, `callr`.
- `i_data_addr` in PC_W: load/store address.
- `i_data_wrdata` in INSTR_W: store data.
- `o_fault` out 1: misaligned PC trap (present only with the macro).

## Operation
- **States:** `FETCH`, `LATCH`, `EXEC`, `DMEM`, `DWAIT`, `HALT`. `HALT` exists only with the macro.
- **FETCH:** `o_mem_addr = PC`, `o_mem_rd = 1` → `LATCH`.
- **LATCH:** `IR <= i_mem_rddata` → `EXEC`.
- **EXEC:** `o_exec = 1` for exactly one cycle.
  - If `i_mem_sel = 0`: update the PC (see below) → `FETCH`.
  - If `i_mem_sel = 1`: → `DMEM`. The PC is not updated yet.
- **DMEM:** `o_mem_addr = i_data_addr`.
  - If `i_mem_write = 1`: `o_mem_wr = 1`, update the PC → `FETCH`.
  - If `i_mem_write = 0`: `o_mem_rd = 1` → `DWAIT`.
- **DWAIT:** `o_ld_valid = 1`, update the PC → `FETCH`.
- **PC update:**
  - `i_pc_enable = 0`: PC unchanged.
  - `i_pc_enable = 1`: PC loads `i_br_target` if `i_pc_src = 00`, `i_rind_target` if `01`, otherwise `PC + 2`.
- **Arithmetic:** PC arithmetic is modulo 2^PC_W; `16'hFFFE + 2` wraps to `16'h0000`.
- **Strobes:** `o_mem_rd` and `o_mem_wr` are never high together. Outside the states listed above, both are 0.
- **IR:** changes only in `LATCH`.
- **Decoder inputs:** `i_pc_src`, `i_pc_enable`, `i_mem_sel` and `i_mem_write` are sampled only in `EXEC`, `DMEM` and `DWAIT`. The IR is stable across those states, so these inputs are stable too.
- **Reset values:** `PC = RESET_PC`, `IR = 0`, state `FETCH`. All strobes, `o_exec`, `o_ld_valid` and `o_fault` are 0. A reset asserted in any state, including mid-load, takes effect at the next edge and drops any pending access.

## Timing
- **Instruction latency:**
  - ALU, move and jump instructions: 3 cycles.
  - Stores: 4 cycles.
  - Loads: 5 cycles.
- **Read latency:** memory read latency is fixed at 1 cycle. There is no wait-state input.
- **Cycle after reset:** the first cycle after reset deasserts is `FETCH`, with `o_mem_addr = RESET_PC`.
- **Target visibility:** a new PC is visible on `o_pc` in the following `FETCH` cycle.

## Configuration
- **`FETCH_ALIGN_CHECK_EN` defined:** if the selected next PC has bit 0 = 1, the PC is not loaded. The FSM enters `HALT` and raises `o_fault = 1`. Both persist until reset, and no memory strobes are issued while in `HALT`.
- **`FETCH_ALIGN_CHECK_EN` undefined:**
  - Bit 0 of the next PC is forced to 0.
  - `HALT` is absent.
  - `o_fault` is absent.

## Structure
- **Package `cpu_pkg`:**
  - `fetch_state_t` enum.
  - `PCSrc` encodings: `PC_BR`, `PC_RIND`, `PC_SEQ`.
  - Instruction field positions: opcode `[4:0]`, Rx `[7:5]`, Ry `[10:8]`, imm8 `[15:8]`, imm11 `[15:5]`.
  - Default `RESET_PC`.
- **Sub-module `fetch_pc_sel`:** combinational next-PC mux plus the alignment check. The PC register, IR and FSM stay in `fetch_unit`.

## Test plan
- **Reset and sequential run:** pulse reset, memory holds `mv` at 0 and `add` at 2 → `o_mem_addr` reads 0, then 2. `o_exec` pulses every 3 cycles. `o_opcode` is 5'b00000, then 5'b00001.
- **Branch:** `i_pc_src = 00`, `i_br_target = 16'h0040` in `EXEC` → next `FETCH` address is `16'h0040`. `i_pc_src = 01`, `i_rind_target = 16'h0100` → `16'h0100`.
- **Load:** `i_mem_sel = 1`, `i_mem_write = 0`, `i_data_addr = 16'h0200`, mem[0x200] = `16'hBEEF` → 5-cycle instruction. `o_ld_valid = 1` with `i_mem_rddata = 16'hBEEF`, and `o_mem_wr` stays 0.
- **Store:** `i_mem_sel = 1`, `i_mem_write = 1`, `i_data_addr = 16'h0210` → `o_mem_wr` is high for exactly 1 cycle at `16'h0210`. Next fetch is at PC+2.
- **PC hold and wrap:** `i_pc_enable = 0` → the same address is re-fetched. PC = `16'hFFFE` with `pc_src = 10` → next fetch at `16'h0000`.
- **Reset mid-load and alignment:** reset asserted in `DMEM` → next cycle is `FETCH` at `RESET_PC` with no `o_ld_valid`. With `FETCH_ALIGN_CHECK_EN` defined, `i_br_target = 16'h0013` → `o_fault = 1` and no further strobes.
